// File: rtl/scatter_pipe_mc.sv
// Multi-lane scatter pipeline: computes per-edge updates by mode and carries each beat
// through PIPE_DEPTH elastic stages with bubble collapse and an update counter.
module scatter_pipe_mc #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned ATTR_W     = 32,
  parameter int unsigned DEST_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES-1:0]          in_lane_mask,
  input  logic [NUM_LANES*32-1:0]       in_weight,
  input  logic [NUM_LANES*ATTR_W-1:0]   in_src_attr,
  input  logic [NUM_LANES*DEST_W-1:0]   in_dest,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES-1:0]          out_lane_mask,
  output logic [NUM_LANES*32-1:0]       out_value,
  output logic [NUM_LANES*DEST_W-1:0]   out_dest,
  input  logic                          cnt_clear,
  output logic [31:0]                   update_count,
  output logic                          busy
);

  localparam int unsigned VW = NUM_LANES * 32;
  localparam int unsigned DW = NUM_LANES * DEST_W;
  localparam int unsigned NS = PIPE_DEPTH - 1;

  // Stage 0 holds the raw beat (mode still attached); stages 1..PIPE_DEPTH-1 hold results.
  logic                 s0_v_q, s0_v_d;
  logic [1:0]           s0_mode_q, s0_mode_d;
  logic [NUM_LANES-1:0] s0_mask_q, s0_mask_d;
  logic [VW-1:0]        s0_weight_q, s0_weight_d;
  logic [VW-1:0]        s0_attr_q, s0_attr_d;
  logic [DW-1:0]        s0_dest_q, s0_dest_d;

  logic [NS-1:0]        p_v_q, p_v_d;
  logic [NUM_LANES-1:0] p_mask_q [NS];
  logic [NUM_LANES-1:0] p_mask_d [NS];
  logic [VW-1:0]        p_value_q [NS];
  logic [VW-1:0]        p_value_d [NS];
  logic [DW-1:0]        p_dest_q [NS];
  logic [DW-1:0]        p_dest_d [NS];

  logic [31:0]          update_count_q, update_count_d;
  logic [PIPE_DEPTH-1:0] stage_v;
  logic [PIPE_DEPTH-1:0] adv;

  logic [NUM_LANES-1:0] c_mask;
  logic [VW-1:0]        c_value;
  logic [DW-1:0]        c_dest;
  logic [31:0]          op_w, op_a, op_val;
  logic [32:0]          op_sum;
  logic                 op_keep;
  logic                 out_hs;

  function automatic logic [31:0] popcnt(input logic [NUM_LANES-1:0] m);
    popcnt = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) popcnt = popcnt + 32'(m[i]);
  endfunction

  // Per-lane operation; infinite attrs are filtered only in the additive modes.
  always_comb begin
    c_mask  = '0;
    c_value = '0;
    c_dest  = '0;
    op_w    = '0;
    op_a    = '0;
    op_val  = '0;
    op_sum  = '0;
    op_keep = 1'b0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      op_w = s0_weight_q[32*k +: 32];
      op_a = s0_attr_q[32*k +: 32];
      case (s0_mode_q)
        2'd0: op_val = op_w * op_a;
        2'd1: op_val = op_a;
        2'd2: begin
          op_sum = {1'b0, op_a} + {1'b0, op_w};
          op_val = op_sum[32] ? 32'hFFFF_FFFF : op_sum[31:0];
        end
        default: begin
          op_sum = {1'b0, op_a} + 33'd1;
          op_val = op_sum[32] ? 32'hFFFF_FFFF : op_sum[31:0];
        end
      endcase
      op_keep = s0_mask_q[k] && !(s0_mode_q[1] && (op_a == 32'hFFFF_FFFF));
      c_mask[k]                      = op_keep;
      c_value[32*k +: 32]            = op_keep ? op_val : 32'd0;
      c_dest[DEST_W*k +: DEST_W]     = op_keep ? s0_dest_q[DEST_W*k +: DEST_W] : '0;
    end
  end

  // Backward advance chain: a stage moves when empty or when its successor moves.
  always_comb begin
    stage_v = {p_v_q, s0_v_q};
    adv     = '0;
    adv[PIPE_DEPTH-1] = !stage_v[PIPE_DEPTH-1] || out_ready;
    for (int j = int'(PIPE_DEPTH) - 2; j >= 0; j--) adv[j] = !stage_v[j] || adv[j+1];
  end

  assign out_hs = out_valid && out_ready;

  always_comb begin
    s0_v_d      = s0_v_q;
    s0_mode_d   = s0_mode_q;
    s0_mask_d   = s0_mask_q;
    s0_weight_d = s0_weight_q;
    s0_attr_d   = s0_attr_q;
    s0_dest_d   = s0_dest_q;
    p_v_d       = p_v_q;
    p_mask_d    = p_mask_q;
    p_value_d   = p_value_q;
    p_dest_d    = p_dest_q;
    update_count_d = update_count_q;

    if (adv[0]) begin
      s0_v_d = in_valid;
      if (in_valid) begin
        s0_mode_d   = mode;
        s0_mask_d   = in_lane_mask;
        s0_weight_d = in_weight;
        s0_dest_d   = in_dest;
        for (int k = 0; k < int'(NUM_LANES); k++)
          s0_attr_d[32*k +: 32] = 32'(in_src_attr[ATTR_W*k +: ATTR_W]);
      end
    end

    // Beats with no live lanes vanish on entry to the output stage.
    if (adv[1]) begin
      p_v_d[0]     = s0_v_q && ((NS != 1) || (|c_mask));
      p_mask_d[0]  = c_mask;
      p_value_d[0] = c_value;
      p_dest_d[0]  = c_dest;
    end
    for (int j = 1; j < int'(NS); j++) begin
      if (adv[j+1]) begin
        p_v_d[j]     = p_v_q[j-1] && ((j != int'(NS) - 1) || (|p_mask_q[j-1]));
        p_mask_d[j]  = p_mask_q[j-1];
        p_value_d[j] = p_value_q[j-1];
        p_dest_d[j]  = p_dest_q[j-1];
      end
    end

    if (cnt_clear)   update_count_d = out_hs ? popcnt(out_lane_mask) : 32'd0;
    else if (out_hs) update_count_d = update_count_q + popcnt(out_lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v_q      <= 1'b0;
      s0_mode_q   <= '0;
      s0_mask_q   <= '0;
      s0_weight_q <= '0;
      s0_attr_q   <= '0;
      s0_dest_q   <= '0;
      p_v_q       <= '0;
      for (int j = 0; j < int'(NS); j++) begin
        p_mask_q[j]  <= '0;
        p_value_q[j] <= '0;
        p_dest_q[j]  <= '0;
      end
      update_count_q <= '0;
    end else begin
      s0_v_q      <= s0_v_d;
      s0_mode_q   <= s0_mode_d;
      s0_mask_q   <= s0_mask_d;
      s0_weight_q <= s0_weight_d;
      s0_attr_q   <= s0_attr_d;
      s0_dest_q   <= s0_dest_d;
      p_v_q       <= p_v_d;
      p_mask_q    <= p_mask_d;
      p_value_q   <= p_value_d;
      p_dest_q    <= p_dest_d;
      update_count_q <= update_count_d;
    end
  end

  assign in_ready      = rst_n && adv[0];
  assign out_valid     = p_v_q[NS-1];
  assign out_lane_mask = p_mask_q[NS-1];
  assign out_value     = p_value_q[NS-1];
  assign out_dest      = p_dest_q[NS-1];
  assign update_count  = update_count_q;
  assign busy          = |stage_v;

endmodule

// File: tb/tb_scatter_pipe_mc.sv
// Directed bench for scatter_pipe_mc (4 lanes, depth 3) with hand-computed expectations.
module tb_scatter_pipe_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_lane_mask;
  logic [127:0] in_weight;
  logic [127:0] in_src_attr;
  logic [127:0] in_dest;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_lane_mask;
  logic [127:0] out_value;
  logic [127:0] out_dest;
  logic         cnt_clear;
  logic [31:0]  update_count;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scatter_pipe_mc #(.NUM_LANES(4), .PIPE_DEPTH(3), .ATTR_W(32), .DEST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_mask(in_lane_mask), .in_weight(in_weight), .in_src_attr(in_src_attr),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_mask(out_lane_mask), .out_value(out_value), .out_dest(out_dest),
    .cnt_clear(cnt_clear), .update_count(update_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] m, input logic [3:0] mk,
                     input logic [127:0] w, input logic [127:0] a, input logic [127:0] d);
    in_valid = v; mode = m; in_lane_mask = mk; in_weight = w; in_src_attr = a; in_dest = d;
  endtask

  initial begin
    logic [31:0] exp_alt [4];
    logic        seen;
    logic        saw_full;
    logic        stalled_prev;
    logic [127:0] held;
    int          sent;
    int          recv;

    exp_alt = '{32'd15, 32'd6, 32'd21, 32'd8};
    rst_n = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    drv(1'b0, 2'd0, 4'h0, '0, '0, '0);
    #3;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_count", 128'(update_count), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);

    // Mode 0 multiply, latency 3
    drv(1'b1, 2'd0, 4'hF, {32'd5, 32'd4, 32'd3, 32'd2}, {4{32'd10}},
        {32'd103, 32'd102, 32'd101, 32'd100});
    tick();
    in_valid = 1'b0;
    tick();
    chk("m0_lat_early", 128'(out_valid), 128'd0);
    tick();
    chk("m0_valid", 128'(out_valid), 128'd1);
    chk("m0_value", out_value, {32'd50, 32'd40, 32'd30, 32'd20});
    chk("m0_dest", out_dest, {32'd103, 32'd102, 32'd101, 32'd100});
    chk("m0_mask", 128'(out_lane_mask), 128'hF);
    tick();
    chk("m0_count", 128'(update_count), 128'd4);
    chk("m0_drained", 128'(out_valid), 128'd0);

    // Mode 2 saturating add with infinity filter on lane 1
    drv(1'b1, 2'd2, 4'hF, {32'd0, 32'd7, 32'd1, 32'h20},
        {32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF0}, {32'd203, 32'd202, 32'd201, 32'd200});
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("m2_valid", 128'(out_valid), 128'd1);
    chk("m2_mask", 128'(out_lane_mask), 128'hD);
    chk("m2_value", out_value, {32'd0, 32'd12, 32'd0, 32'hFFFF_FFFF});
    chk("m2_dest", out_dest, {32'd203, 32'd202, 32'd0, 32'd200});
    tick();
    chk("m2_count", 128'(update_count), 128'd7);

    // Mode 3 with all lanes infinite is discarded
    drv(1'b1, 2'd3, 4'hF, '0, {4{32'hFFFF_FFFF}}, {4{32'd9}});
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin tick(); seen |= out_valid; end
    chk("m3_inf_no_valid", 128'(seen), 128'd0);
    chk("m3_inf_busy", 128'(busy), 128'd0);
    chk("m3_inf_count", 128'(update_count), 128'd7);

    // Empty-mask beat is discarded
    drv(1'b1, 2'd0, 4'h0, {4{32'd1}}, {4{32'd1}}, {4{32'd1}});
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (3) begin tick(); seen |= out_valid; end
    chk("mask0_no_valid", 128'(seen), 128'd0);
    chk("mask0_count", 128'(update_count), 128'd7);

    // Alternating modes 0/1, back to back
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drv(1'b1, (i % 2 == 1) ? 2'd1 : 2'd0, 4'hF, {4{32'd3}}, {4{32'(i + 5)}}, {4{32'(i)}});
      else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        chk("alt_valid", 128'(out_valid), 128'd1);
        chk("alt_value", out_value, {4{exp_alt[i-2]}});
      end
    end
    tick();
    chk("alt_count", 128'(update_count), 128'd23);

    // Ten back-to-back beats with a stall window
    sent = 0; recv = 0; saw_full = 1'b0; stalled_prev = 1'b0; held = '0;
    for (int c = 0; c < 40 && recv < 10; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 10) drv(1'b1, 2'd1, 4'hF, '0, {4{32'(300 + sent)}}, {4{32'(sent)}});
      else in_valid = 1'b0;
      #1;
      if (stalled_prev) chk("b2b_hold", out_value, held);
      if (out_valid) begin
        if (out_ready) begin
          chk("b2b_order", 128'(out_value[31:0]), 128'(300 + recv));
          recv++;
        end
        stalled_prev = !out_ready;
        held = out_value;
      end else begin
        stalled_prev = 1'b0;
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_recv", 128'(recv), 128'd10);
    chk("b2b_sent", 128'(sent), 128'd10);
    chk("b2b_full_backpressure", 128'(saw_full), 128'd1);
    tick(); tick(); tick();
    chk("b2b_count", 128'(update_count), 128'd63);
    chk("b2b_idle", 128'(busy), 128'd0);

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 2'd1, 4'hF, '0, {4{32'(50 + i)}}, {4{32'd7}});
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 128'(out_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_value", out_value, 128'd0);
    chk("mid_rst_dest", out_dest, 128'd0);
    chk("mid_rst_count", 128'(update_count), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= out_valid; end
    chk("post_rst_no_emit", 128'(seen), 128'd0);
    chk("post_rst_count", 128'(update_count), 128'd0);

    // Clear coinciding with a handshake, then clear alone
    drv(1'b1, 2'd1, 4'b0011, '0, {4{32'd1}}, {4{32'd1}});
    tick();
    in_valid = 1'b0;
    tick(); tick();
    tick();
    chk("pre_clr_count", 128'(update_count), 128'd2);
    drv(1'b1, 2'd1, 4'b0111, '0, {4{32'd1}}, {4{32'd1}});
    tick();
    in_valid = 1'b0;
    tick(); tick();
    cnt_clear = 1'b1;
    tick();
    chk("clr_hs_count", 128'(update_count), 128'd3);
    tick();
    chk("clr_only_count", 128'(update_count), 128'd0);
    cnt_clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scatter_pipe_mc.md
SCATTER_PIPE_MC -- requirements
Module: scatter_pipe_mc

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: parallel edge lanes per beat (1..16).
REQ-002 SHALL have parameter PIPE_DEPTH, default 3: pipeline stages (2..8).
REQ-003 SHALL have parameter ATTR_W, default 32: source attribute width (<=32; zero-extended to 32 internally).
REQ-004 SHALL have parameter DEST_W, default 32: destination vertex ID width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port mode  in  2  op select sampled with each input beat.
REQ-009 SHALL have port in_valid  in  1  input beat valid.
REQ-010 SHALL have port in_ready  out  1  input beat accepted when in_valid & in_ready.
REQ-011 SHALL have port in_lane_mask  in  NUM_LANES  per-lane edge valid.
REQ-012 SHALL have port in_weight  in  NUM_LANES*32  edge weights; lane k at [32k+31:32k].
REQ-013 SHALL have port in_src_attr  in  NUM_LANES*ATTR_W  source attributes.
REQ-014 SHALL have port in_dest  in  NUM_LANES*DEST_W  edge destinations.
REQ-015 SHALL have port out_valid  out  1  update beat valid.
REQ-016 SHALL have port out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-017 SHALL have port out_lane_mask  out  NUM_LANES  per-lane update valid.
REQ-018 SHALL have port out_value  out  NUM_LANES*32  update values.
REQ-019 SHALL have port out_dest  out  NUM_LANES*DEST_W  update destinations.
REQ-020 SHALL have port cnt_clear  in  1  synchronous clear of update_count.
REQ-021 SHALL have port update_count  out  32  total lane updates emitted.
REQ-022 SHALL have port busy  out  1  any pipeline stage holds a valid beat.

Function
REQ-023 SHALL compute per lane, by mode: 0 = weight*attr (low 32 bits of product); 1 = attr (pass); 2 = attr+weight saturating at 32'hFFFFFFFF; 3 = attr+1 saturating.
REQ-024 SHALL carry mode, mask, dest and value through every stage with the beat, so a mode change between beats never affects in-flight beats.
REQ-025 SHALL in modes 2 and 3 clear a lane's mask bit when its attr equals all-ones (infinity); modes 0/1 never filter.
REQ-026 SHALL have latency exactly PIPE_DEPTH cycles from input handshake to out_valid when out_ready stays high.
REQ-027 SHALL advance each stage when the next stage is empty or advancing (bubble collapse); the last stage advances on out_ready or when empty.
REQ-028 SHALL drive in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready permitted.
REQ-029 SHALL hold out_valid, out_lane_mask, out_value and out_dest stable while out_valid & !out_ready.
REQ-030 SHALL discard, without asserting out_valid, any beat whose mask is all-zero at the last stage, including beats accepted with in_lane_mask = 0.
REQ-031 SHALL sustain one beat per cycle with out_ready held high.
REQ-032 SHALL increment update_count by popcount(out_lane_mask) on each output handshake, wrapping mod 2^32.
REQ-033 SHALL, when cnt_clear and a handshake coincide, load update_count with that beat's popcount.
REQ-034 SHALL drive out_value and out_dest for masked-off lanes as 0.

Reset
REQ-035 SHALL on rst_n low immediately clear all stage valids, out_valid, out_lane_mask, out_value, out_dest, update_count, busy to 0.
REQ-036 SHALL drive in_ready = 0 while rst_n low and 1 in the first cycle after release.
REQ-037 SHALL drop all in-flight beats when reset asserts mid-operation; none emerge after release.

Verification
REQ-038 SHALL verify mode 0, NUM_LANES=4, weights {2,3,4,5}, attrs {10,10,10,10}, mask 4'hF -> after 3 cycles values {20,30,40,50}, dests unchanged, update_count=4.
REQ-039 SHALL verify mode 2, attr lane1 = 32'hFFFFFFFF, lane0 attr 32'hFFFFFFF0 weight 32'h20 -> lane0 value 32'hFFFFFFFF, mask 4'b1101.
REQ-040 SHALL verify 10 back-to-back beats with out_ready low cycles 4-7 -> no beat lost or duplicated, outputs stable while stalled, in_ready drops when full.
REQ-041 SHALL verify mode 3 beat with all attrs all-ones -> no out_valid, update_count unchanged, busy returns 0.
REQ-042 SHALL verify alternating modes 0/1 per beat -> each output reflects its own beat's mode.
REQ-043 SHALL verify rst_n pulsed low with 3 beats in flight -> outputs 0 immediately, no beats emitted after release, update_count=0.
